qos_vc_arbiter: RTL

Parametrised N-channel virtual-channel arbiter for the PCIe QoS module. It replaces the fixed 4-way selector with true request-driven arbitration. Four modes are selectable at run time: round robin, table-driven, weighted round robin and weighted table. The block sits between the per-VC queues and the link transmit mux, and issues one registered one-hot grant per cycle.

---
 rtl/qos_vc_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/qos_vc_arbiter.sv
// N-channel virtual-channel arbiter: round robin, table, weighted RR and weighted table modes.
// One registered one-hot grant per cycle, chosen from the requests sampled at the previous edge.
module qos_vc_arbiter #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned TBL_DEPTH = 16,
    parameter int unsigned PTR_W     = 4,
    parameter int unsigned WGT_W     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enb,
    input  logic [1:0]                  sel,
    input  logic [N_CH-1:0]             req,
    input  logic [N_CH*WGT_W-1:0]       weight,
    input  logic [TBL_DEPTH*IDX_W-1:0]  tbl_data,
    input  logic                        tbl_load,
    output logic [N_CH-1:0]             gnt,
    output logic                        gnt_valid,
    output logic [IDX_W-1:0]            gnt_id,
    output logic [PTR_W-1:0]            tbl_ptr
);

    typedef enum logic [1:0] {
        MODE_RR   = 2'b00,
        MODE_TBL  = 2'b01,
        MODE_WRR  = 2'b10,
        MODE_WTBL = 2'b11
    } mode_t;

    mode_t              sel_q;
    logic [IDX_W-1:0]   rr_ptr;
    logic [WGT_W-1:0]   credit;
    logic [IDX_W-1:0]   tbl [TBL_DEPTH];
    logic [WGT_W-1:0]   wgt [N_CH];

    logic               mode_chg;
    logic [IDX_W-1:0]   base_rr;
    logic [WGT_W-1:0]   base_cr;
    logic [PTR_W-1:0]   base_tp;

    logic               rr_found;
    logic [IDX_W-1:0]   rr_win;
    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   slot_ch;
    logic               slot_hit;

    logic [N_CH-1:0]    gnt_nxt;
    logic [IDX_W-1:0]   id_nxt;
    logic [IDX_W-1:0]   rr_nxt;
    logic [WGT_W-1:0]   cr_nxt;
    logic [PTR_W-1:0]   tp_nxt;
    logic [WGT_W-1:0]   used;

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_wgt
        assign wgt[i] = weight[i*WGT_W +: WGT_W];
    end

    function automatic logic [IDX_W-1:0] next_ch(input logic [IDX_W-1:0] c);
        return (c == IDX_W'(N_CH - 1)) ? '0 : c + 1'b1;
    endfunction

    // A mode switch arbitrates as if pointers and credit had just been cleared
    assign mode_chg = enb && (sel != sel_q);
    assign base_rr  = mode_chg ? '0 : rr_ptr;
    assign base_cr  = mode_chg ? '0 : credit;
    assign base_tp  = mode_chg ? '0 : tbl_ptr;

    // Cyclic first-requester search starting at base_rr
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        cand     = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand = {1'b0, base_rr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_CH)) cand = cand - (IDX_W+1)'(N_CH);
            if (!rr_found && req[cand[IDX_W-1:0]]) begin
                rr_found = 1'b1;
                rr_win   = cand[IDX_W-1:0];
            end
        end
    end

    // Out-of-range slot entries behave like idle channels
    assign slot_ch  = tbl[base_tp];
    assign slot_hit = ({1'b0, slot_ch} < (IDX_W+1)'(N_CH)) && req[slot_ch];

    always_comb begin
        gnt_nxt = '0;
        id_nxt  = '0;
        rr_nxt  = rr_ptr;
        cr_nxt  = credit;
        tp_nxt  = tbl_ptr;
        used    = '0;
        if (enb) begin
            rr_nxt = base_rr;
            cr_nxt = base_cr;
            tp_nxt = base_tp;
            case (mode_t'(sel))
                MODE_RR: begin
                    if (rr_found) begin
                        gnt_nxt[rr_win] = 1'b1;
                        id_nxt          = rr_win;
                        rr_nxt          = next_ch(rr_win);
                    end
                end
                MODE_TBL: begin
                    tp_nxt = base_tp + 1'b1;
                    if (slot_hit) begin
                        gnt_nxt[slot_ch] = 1'b1;
                        id_nxt           = slot_ch;
                    end
                end
                MODE_WRR: begin
                    if (rr_found) begin
                        gnt_nxt[rr_win] = 1'b1;
                        id_nxt          = rr_win;
                        used            = (rr_win == base_rr) ? base_cr : '0;
                        if (used >= wgt[rr_win]) begin
                            rr_nxt = next_ch(rr_win);
                            cr_nxt = '0;
                        end else begin
                            rr_nxt = rr_win;
                            cr_nxt = used + 1'b1;
                        end
                    end
                end
                MODE_WTBL: begin
                    if (slot_hit) begin
                        gnt_nxt[slot_ch] = 1'b1;
                        id_nxt           = slot_ch;
                        if (base_cr >= wgt[slot_ch]) begin
                            tp_nxt = base_tp + 1'b1;
                            cr_nxt = '0;
                        end else begin
                            cr_nxt = base_cr + 1'b1;
                        end
                    end else begin
                        tp_nxt = base_tp + 1'b1;
                        cr_nxt = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs; a table load is honoured regardless of enb
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            tbl_ptr   <= '0;
            rr_ptr    <= '0;
            credit    <= '0;
            sel_q     <= MODE_RR;
            for (int k = 0; k < int'(TBL_DEPTH); k++) tbl[k] <= '0;
        end else begin
            gnt       <= gnt_nxt;
            gnt_valid <= |gnt_nxt;
            gnt_id    <= id_nxt;
            tbl_ptr   <= tp_nxt;
            rr_ptr    <= rr_nxt;
            credit    <= cr_nxt;
            if (enb) sel_q <= mode_t'(sel);
            if (tbl_load) begin
                for (int k = 0; k < int'(TBL_DEPTH); k++) tbl[k] <= tbl_data[k*IDX_W +: IDX_W];
            end
        end
    end

endmodule
